intr_handler_mc: RTL and testbench

- Parametrised multi-channel successor to the single-channel ITC-style interrupt handler FSM.
- Arbitrates NUM_CH request lines (eql) with round-robin fairness, masking and a per-request acknowledge timeout.
- Measures service length of each interrupt (cont_eql held high).
- Sits between peripheral request lines and the service sequencer in the same benchmark-style control designs.

---
 rtl/intr_handler_mc.sv | 79 +++++++
 tb/tb_intr_handler_mc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/intr_handler_mc.sv
// intr_handler_mc: round-robin multi-channel interrupt handler with ack timeout and service-length capture
module intr_handler_mc #(
  parameter int NUM_CH  = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] eql,
  input  logic [NUM_CH-1:0] mask,
  input  logic              cont_eql,
  output logic              ackout,
  output logic              enable_count,
  output logic [ID_W-1:0]   grant_id,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  svc_len,
  output logic              timeout_err
);
  typedef enum logic [2:0] {
    INIT = 3'd0, WAIT = 3'd1, ENIN = 3'd2, ENIN_W = 3'd3,
    INTR = 3'd4, INTR_1 = 3'd5, INTR_W = 3'd6
  } state_t;
  localparam logic [ID_W:0] NCH = (ID_W+1)'(NUM_CH);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0] rr_ptr, off, pick, gid_inc;
  logic [ID_W:0] sum;
  logic [NUM_CH-1:0] active, rot;
  logic req_g, rereq, tmo;
  assign active  = eql & ~mask;
  // rot[k] is the request k positions above rr_ptr, so the lowest set bit wins
  assign rot     = NUM_CH'({active, active} >> rr_ptr);
  assign sum     = {1'b0, rr_ptr} + {1'b0, off};
  assign pick    = sum >= NCH ? ID_W'(sum - NCH) : ID_W'(sum);
  assign gid_inc = grant_id == ID_W'(NUM_CH-1) ? '0 : grant_id + 1'b1;
  assign req_g   = eql[grant_id];
  assign rereq   = eql[grant_id] & ~mask[grant_id];
  assign tmo     = cnt == CNT_W'(TIMEOUT-1);
  always_comb begin
    off = '0;
    for (int k = NUM_CH-1; k >= 0; k--) if (rot[k]) off = ID_W'(k);
  end
  always_ff @(posedge clock) state <= reset ? INIT : state_nx;
  always_comb begin
    case (state)
      INIT:    state_nx = WAIT;
      WAIT:    state_nx = |active ? ENIN : WAIT;
      ENIN:    state_nx = ENIN_W;
      ENIN_W:  state_nx = !req_g ? INTR : tmo ? WAIT : ENIN_W;
      INTR:    state_nx = cont_eql ? INTR : INTR_1;
      INTR_1:  state_nx = INTR_W;
      INTR_W:  state_nx = rereq ? ENIN : WAIT;
      default: state_nx = INIT;
    endcase
  end
  always_comb begin
    ackout       = state == ENIN;
    enable_count = state == ENIN_W || state == INTR;
    state_o      = state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      rr_ptr      <= '0;
      grant_id    <= '0;
      svc_len     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= state == ENIN_W && req_g && tmo;
      if (state == WAIT && |active) grant_id <= pick;
      if (state == ENIN || (state == ENIN_W && !req_g)) cnt <= '0;
      else if (state == ENIN_W && !tmo) cnt <= cnt + 1'b1;
      else if (state == INTR && cont_eql && cnt != '1) cnt <= cnt + 1'b1;
      if (state == INTR && !cont_eql) svc_len <= cnt;
      if ((state == ENIN_W && req_g && tmo) || (state == INTR_W && !rereq)) rr_ptr <= gid_inc;
    end
  end
endmodule

// File: tb/tb_intr_handler_mc.sv
// tb_intr_handler_mc: directed literal checks plus randomized run against a behavioural model
module tb_intr_handler_mc;
  localparam int NUM_CH = 4, ID_W = 2, CNT_W = 4, TIMEOUT = 10;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clock = 1'b0, reset = 1'b1, cont_eql = 1'b0;
  logic [NUM_CH-1:0] eql = '0, mask = '0;
  logic ackout, enable_count, timeout_err;
  logic [ID_W-1:0] grant_id;
  logic [2:0] state_o;
  logic [CNT_W-1:0] svc_len;
  int checks = 0, errors = 0;
  int m_ph = 0, m_cnt = 0, m_rr = 0, m_gid = 0, m_svc = 0, m_terr = 0;
  bit chk_en = 1'b0;

  intr_handler_mc #(.NUM_CH(NUM_CH), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .eql(eql), .mask(mask), .cont_eql(cont_eql),
    .ackout(ackout), .enable_count(enable_count), .grant_id(grant_id),
    .state_o(state_o), .svc_len(svc_len), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  task automatic wait_state(input int code);
    int n = 0;
    while (int'(state_o) != code && n < 60) begin
      n++;
      @(negedge clock);
    end
    chk("wait_state", int'(state_o), code);
  endtask

  // Phases use the externally visible state codes; counters are plain integers
  always @(posedge clock) begin
    int a;
    bit found;
    a = int'(eql & ~mask);
    if (reset) begin
      m_ph = 0; m_cnt = 0; m_rr = 0; m_gid = 0; m_svc = 0; m_terr = 0;
    end else begin
      m_terr = 0;
      if (m_ph == 0) m_ph = 1;
      else if (m_ph == 1) begin
        found = 0;
        for (int i = 0; i < NUM_CH; i++)
          if (!found && ((a >> ((m_rr + i) % NUM_CH)) & 1) != 0) begin
            found = 1;
            m_gid = (m_rr + i) % NUM_CH;
          end
        if (found) m_ph = 2;
      end else if (m_ph == 2) begin
        m_cnt = 0; m_ph = 3;
      end else if (m_ph == 3) begin
        if (((int'(eql) >> m_gid) & 1) == 0) begin m_ph = 4; m_cnt = 0; end
        else if (m_cnt == TIMEOUT - 1) begin m_terr = 1; m_rr = (m_gid + 1) % NUM_CH; m_ph = 1; end
        else m_cnt++;
      end else if (m_ph == 4) begin
        if (cont_eql) m_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
        else begin m_svc = m_cnt; m_ph = 5; end
      end else if (m_ph == 5) m_ph = 6;
      else if (((a >> m_gid) & 1) != 0) m_ph = 2;
      else begin m_rr = (m_gid + 1) % NUM_CH; m_ph = 1; end
    end
  end

  always @(negedge clock) if (chk_en) begin
    chk("state_o", int'(state_o), m_ph);
    chk("ackout", int'(ackout), int'(m_ph == 2));
    chk("enable_count", int'(enable_count), int'(m_ph == 3 || m_ph == 4));
    if (m_ph > 1) chk("grant_id", int'(grant_id), m_gid);
    chk("svc_len", int'(svc_len), m_svc);
    chk("timeout_err", int'(timeout_err), m_terr);
  end

  initial begin
    int n;
    chk_en = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_state", int'(state_o), 0);
    chk("rst_outs", int'({ackout, enable_count, grant_id, svc_len, timeout_err}), 0);
    @(negedge clock); chk("idle_wait1", int'(state_o), 1);
    @(negedge clock); chk("idle_wait2", int'(state_o), 1);
    eql = 4'b0110;
    @(negedge clock);
    chk("prio_state", int'(state_o), 2);
    chk("prio_ack", int'(ackout), 1);
    chk("prio_gid", int'(grant_id), 1);
    @(negedge clock);
    chk("ack_one_cycle", int'(ackout), 0);
    n = 0;
    while (state_o == 3'd3 && n < 30) begin n++; @(negedge clock); end
    chk("timeout_dwell", n, 10);
    chk("timeout_state", int'(state_o), 1);
    chk("timeout_pulse", int'(timeout_err), 1);
    @(negedge clock);
    chk("timeout_pulse_end", int'(timeout_err), 0);
    chk("rr_after_timeout", int'(grant_id), 2);
    eql = 4'b0010;
    wait_state(4);
    cont_eql = 1'b1;
    repeat (5) @(negedge clock);
    cont_eql = 1'b0;
    wait_state(5);
    chk("svc_len_5", int'(svc_len), 5);
    eql = '0;
    wait_state(1);
    eql = 4'b0011;
    @(negedge clock);
    chk("rr_wrap_gid", int'(grant_id), 0);
    eql = '0;
    wait_state(4);
    cont_eql = 1'b1;
    repeat (20) @(negedge clock);
    cont_eql = 1'b0;
    wait_state(5);
    chk("svc_len_sat", int'(svc_len), 15);
    wait_state(1);
    mask = 4'b0010; eql = 4'b0010;
    repeat (5) @(negedge clock);
    chk("masked_wait", int'(state_o), 1);
    mask = '0; eql = 4'b0001;
    @(negedge clock);
    eql = '0;
    wait_state(4);
    cont_eql = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_ack", int'(ackout), 0);
    chk("midrst_en", int'(enable_count), 0);
    chk("midrst_svc", int'(svc_len), 0);
    reset = 1'b0; cont_eql = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 3) == 0) eql = NUM_CH'($urandom);
      if ($urandom_range(0, 15) == 0) mask = NUM_CH'($urandom);
      cont_eql = $urandom_range(0, 3) != 0;
    end
    @(negedge clock);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
